// File: rtl/alu_exec.sv
// alu_exec: command sequencer for an external combinational Hack-style ALU.
// Runs single ALU ops or 8-cycle shift-add multiplies and holds the result.
module alu_exec (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_ctrl,
    input  logic       cmd_mul,
    input  logic       cmd_use_acc,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       zx,
    output logic       nx,
    output logic       zy,
    output logic       ny,
    output logic       f,
    output logic       no,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    input  logic [7:0] alu_o,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_zr,
    output logic       res_ng,
    output logic [7:0] acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [5:0] CTRL_ADD = 6'b000010;

    state_t     state;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [5:0] ctrl_q;
    logic [2:0] cnt;
    logic [7:0] partial;
    logic [7:0] res_q;
    logic       zr_q;
    logic       ng_q;

    logic [5:0] ctrl_drv;
    logic       bit_set;
    logic [7:0] mul_next;
    logic [7:0] wr_val;

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == HOLD);
    assign res_data  = res_q;
    assign acc       = res_q;
    assign res_zr    = zr_q;
    assign res_ng    = ng_q;

    assign {zx, nx, zy, ny, f, no} = ctrl_drv;

    assign bit_set  = y_q[cnt];
    assign mul_next = bit_set ? alu_o : partial;
    assign wr_val   = (state == EXEC) ? alu_o : mul_next;

    // ALU drive: latched op in EXEC, partial + shifted X on set multiplier bits
    always_comb begin
        ctrl_drv = '0;
        alu_x    = '0;
        alu_y    = '0;
        unique case (state)
            EXEC: begin
                ctrl_drv = ctrl_q;
                alu_x    = x_q;
                alu_y    = y_q;
            end
            MUL: begin
                if (bit_set) begin
                    ctrl_drv = CTRL_ADD;
                    alu_x    = partial;
                    alu_y    = x_q << cnt;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: accept, execute or multiply, then hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ctrl_q  <= '0;
            cnt     <= '0;
            partial <= '0;
            res_q   <= '0;
            zr_q    <= 1'b1;
            ng_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        x_q     <= cmd_use_acc ? res_q : cmd_a;
                        y_q     <= cmd_b;
                        ctrl_q  <= cmd_ctrl;
                        cnt     <= '0;
                        partial <= '0;
                        state   <= cmd_mul ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    res_q <= wr_val;
                    zr_q  <= (wr_val == 8'd0);
                    ng_q  <= wr_val[7];
                    state <= HOLD;
                end
                MUL: begin
                    partial <= mul_next;
                    if (cnt == 3'd7) begin
                        res_q <= wr_val;
                        zr_q  <= (wr_val == 8'd0);
                        ng_q  <= wr_val[7];
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed checks of alu_exec against a behavioural Hack ALU.
// Expected results are hand-computed constants.
module tb_alu_exec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_ctrl;
    logic       cmd_mul;
    logic       cmd_use_acc;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       zx, nx, zy, ny, f, no;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [7:0] alu_o;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zr;
    logic       res_ng;
    logic [7:0] acc;

    int errs = 0;
    int nchk = 0;
    int lat;
    logic [21:0] drv [0:19];

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ctrl(cmd_ctrl), .cmd_mul(cmd_mul),
        .cmd_use_acc(cmd_use_acc),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .alu_x(alu_x), .alu_y(alu_y), .alu_o(alu_o),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zr(res_zr), .res_ng(res_ng),
        .acc(acc)
    );

    // Downstream combinational Hack ALU
    always_comb begin
        logic [7:0] xa, ya, oa;
        xa = zx ? 8'd0 : alu_x;
        xa = nx ? ~xa : xa;
        ya = zy ? 8'd0 : alu_y;
        ya = ny ? ~ya : ya;
        oa = f ? xa + ya : xa & ya;
        alu_o = no ? ~oa : oa;
    end

    function automatic logic [21:0] drive_now();
        return {zx, nx, zy, ny, f, no, alu_x, alu_y};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] c, input logic m,
                         input logic u, input logic [7:0] a,
                         input logic [7:0] b);
        @(negedge clk);
        cmd_ctrl    = c;
        cmd_mul     = m;
        cmd_use_acc = u;
        cmd_a       = a;
        cmd_b       = b;
        cmd_valid   = 1'b1;
        check("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result();
        lat = 0;
        while (!res_valid && lat < 20) begin
            drv[lat] = drive_now();
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_take", {cmd_ready, res_valid}, 2'b10);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_ctrl    = '0;
        cmd_mul     = 1'b0;
        cmd_use_acc = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        res_ready   = 1'b0;
        for (int i = 0; i < 20; i++) drv[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_flags", {res_zr, res_ng}, 2'b10);
        check("rst_acc", acc, 0);
        check("rst_drive", drive_now(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", cmd_ready, 1);

        // X+Y
        issue(6'b000010, 1'b0, 1'b0, 8'd20, 8'd15);
        wait_result();
        check("add_lat", lat, 1);
        check("add_drive", drv[0], {6'b000010, 8'd20, 8'd15});
        check("add_data", res_data, 35);
        check("add_flags", {res_zr, res_ng}, 2'b00);
        check("add_acc", acc, 35);
        check("hold_drive", drive_now(), 0);
        check("hold_ready", cmd_ready, 0);
        release_result();

        // X-Y with X from acc
        issue(6'b010011, 1'b0, 1'b1, 8'd99, 8'd15);
        wait_result();
        check("sub_lat", lat, 1);
        check("sub_drive", drv[0], {6'b010011, 8'd35, 8'd15});
        check("sub_data", res_data, 20);
        check("sub_flags", {res_zr, res_ng}, 2'b00);
        release_result();

        // Y-X with X from acc
        issue(6'b000111, 1'b0, 1'b1, 8'd0, 8'd15);
        wait_result();
        check("rsub_data", res_data, 251);
        check("rsub_flags", {res_zr, res_ng}, 2'b01);
        check("rsub_acc", acc, 251);
        release_result();

        // 13*11
        issue(6'b111111, 1'b1, 1'b0, 8'd13, 8'd11);
        wait_result();
        check("mul1_lat", lat, 8);
        check("mul1_c0", drv[0], {6'b000010, 8'd0, 8'd13});
        check("mul1_c1", drv[1], {6'b000010, 8'd13, 8'd26});
        check("mul1_c2", drv[2], 0);
        check("mul1_c3", drv[3], {6'b000010, 8'd39, 8'd104});
        check("mul1_data", res_data, 143);
        check("mul1_flags", {res_zr, res_ng}, 2'b01);
        check("mul1_acc", acc, 143);
        release_result();

        // 20*15 with backpressure
        issue(6'b000000, 1'b1, 1'b0, 8'd20, 8'd15);
        wait_result();
        check("mul2_lat", lat, 8);
        check("mul2_data", res_data, 44);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmd_valid = k[0];
            cmd_a     = 8'(k + 1);
            cmd_b     = 8'(k + 7);
            cmd_mul   = 1'b0;
            @(posedge clk);
            #1;
            check("bp_hold",
                  {cmd_ready, res_valid, res_data, res_zr, res_ng},
                  {1'b0, 1'b1, 8'd44, 1'b0, 1'b0});
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_exit_no_accept", {cmd_ready, res_valid}, 2'b10);
        check("bp_acc", acc, 44);
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b0;

        // 0*200
        issue(6'b000000, 1'b1, 1'b0, 8'd0, 8'd200);
        wait_result();
        check("mul3_data", res_data, 0);
        check("mul3_flags", {res_zr, res_ng}, 2'b10);
        release_result();

        // reset during multiply cycle 4
        issue(6'b000000, 1'b1, 1'b0, 8'd13, 8'd11);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", res_valid, 0);
        check("midrst_acc", acc, 0);
        check("midrst_drive", drive_now(), 0);
        check("midrst_flags", {res_zr, res_ng}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'b000000, 1'b1, 1'b0, 8'd3, 8'd5);
        wait_result();
        check("mul4_lat", lat, 8);
        check("mul4_data", res_data, 15);
        check("mul4_acc", acc, 15);
        release_result();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-004 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid&&cmd_ready at clk edge.
REQ-005 SHALL have port cmd_ctrl, input, 6 bits: {zx,nx,zy,ny,f,no} for a single ALU op.
REQ-006 SHALL have port cmd_mul, input, 1 bit: 1 = multiply op (cmd_ctrl ignored).
REQ-007 SHALL have port cmd_use_acc, input, 1 bit: 1 = X operand taken from acc instead of cmd_a.
REQ-008 SHALL have ports cmd_a and cmd_b, input, 8 bits each: X and Y operands.
REQ-009 SHALL have ports zx, nx, zy, ny, f, no, output, 1 bit each: ALU control, driven to the downstream ALU.
REQ-010 SHALL have ports alu_x and alu_y, output, 8 bits each: ALU operands.
REQ-011 SHALL have port alu_o, input, 8 bits: combinational ALU result.
REQ-012 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 8), res_zr (output, 1), res_ng (output, 1): result handshake and flags.
REQ-013 SHALL have port acc, output, 8 bits: accumulator, last completed result.

Function
REQ-014 SHALL implement states IDLE, EXEC, MUL, HOLD; cmd_ready=1 only in IDLE.
REQ-015 SHALL, on accept, latch X operand (acc if cmd_use_acc else cmd_a), cmd_b and cmd_ctrl; go to EXEC if cmd_mul=0, else MUL with bit counter=0 and partial=0.
REQ-016 SHALL, in EXEC, drive latched ctrl/X/Y to the ALU, capture alu_o into res_data and acc at the cycle-ending edge, go to HOLD.
REQ-017 SHALL, in MUL, run exactly 8 cycles, i=0..7: if Y[i]=1 drive ctrl=000010, alu_x=partial, alu_y=(X<<i) truncated to 8 bits, partial<=alu_o; if Y[i]=0 partial unchanged.
REQ-018 SHALL, at end of MUL cycle i=7, write final partial (product mod 256) to res_data and acc, go to HOLD.
REQ-019 SHALL hold res_valid=1 only in HOLD; res_data/res_zr/res_ng stable while res_valid=1 and res_ready=0.
REQ-020 SHALL go HOLD->IDLE on res_ready=1; no new command accepted in that same cycle.
REQ-021 SHALL set res_zr=(res_data==0), res_ng=res_data[7], registered with res_data.
REQ-022 SHALL drive all ALU controls and alu_x/alu_y to 0 in IDLE and HOLD, and during MUL cycles with Y[i]=0.
REQ-023 SHALL give latency: accept at edge N -> res_valid at edge N+1 (EXEC) or N+8 (MUL).
REQ-024 SHALL ignore cmd_valid and all cmd_* inputs outside IDLE; arithmetic wraps modulo 256, no overflow flag.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, cmd_ready=1 after release, res_valid=0, res_data=0, res_zr=1, res_ng=0, acc=0, partial=0, counter=0, ALU outputs 0.
REQ-026 SHALL abort any EXEC/MUL/HOLD on reset with no result delivered; first command after release is processed normally.

Verification
REQ-027 SHALL cover X+Y: ctrl=000010, a=20, b=15, res_ready=1 -> res_valid one cycle after accept, res_data=35, zr=0, ng=0, acc=35.
REQ-028 SHALL cover use_acc chain: acc=35, ctrl=010011 (X-Y), use_acc=1, b=15 -> res_data=20; then ctrl=000111 (Y-X), b=15 -> res_data=251, ng=1.
REQ-029 SHALL cover multiply: a=13, b=11, mul=1 -> res_valid 8 cycles after accept, res_data=143, ng=1; a=20, b=15 -> 44 (300 mod 256); a=0, b=200 -> 0, zr=1.
REQ-030 SHALL cover backpressure: res_ready=0 for 5 cycles after result -> res_valid and res_data stable, cmd_ready=0, cmd_valid pulses ignored; res_ready=1 -> IDLE next edge.
REQ-031 SHALL cover reset mid-MUL: rst_n low at MUL cycle 4 -> res_valid=0, acc=0 immediately; after release a=3, b=5 mul -> 15.
